// File: rtl/fp_addsub_seq.sv
// fp_addsub_seq -- multi-cycle binary32 add/subtract sequencer.
//
// Accepts two IEEE-754 single-precision operands and an add/subtract opcode
// over a valid/ready handshake. The mantissa datapath steps through ALIGN,
// ADD, NORM and ROUND states, one shift per cycle, before presenting the
// packed result in DONE. Only one operation is in flight at a time.
// Denormal inputs are flushed to zero. Rounding is round-to-nearest-even.
//
// Ports:
//   clk        in   clock, all state updates on the rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   operand pair presented
//   in_ready   out  high iff the block is idle and can accept
//   a, b       in   binary32 operands
//   op         in   0 = a+b, 1 = a-b
//   out_valid  out  result valid, held until taken
//   out_ready  in   consumer accepts the result
//   result     out  packed binary32 result
//   overflow   out  result saturated to +/-infinity (qualified by out_valid)
//   busy       out  high in any state other than IDLE
module fp_addsub_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        overflow,
  output logic        busy
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ALIGN = 3'd1;
  localparam logic [2:0] ADD   = 3'd2;
  localparam logic [2:0] NORM  = 3'd3;
  localparam logic [2:0] ROUND = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  logic [2:0]         state;
  logic               sr;        // result sign
  logic               eop;       // effective subtract
  logic               zero_r;    // result is an exact/flushed zero
  logic signed [9:0]  exp_r;     // working exponent, wide to catch under/overflow
  logic [26:0]        mbig;      // base mantissa {hidden, frac, g, r, s}
  logic [26:0]        msml;      // mantissa being aligned to the base
  logic [4:0]         cnt;       // remaining alignment shifts
  logic [31:0]        result_r;
  logic               ovf_r;

  // Round-to-nearest-even on guard/round/sticky; 25-bit return keeps the carry.
  function automatic logic [24:0] round_rne(input logic [26:0] m);
    logic up;
    up = m[2] & (m[1] | m[0] | m[3]);
    return {1'b0, m[26:3]} + {24'd0, up};
  endfunction

  // Pack the rounded value, saturating to infinity when the exponent overflows.
  function automatic logic [32:0] pack_sat(input logic s, input logic signed [9:0] e,
                                           input logic [22:0] frac);
    if (e >= 10'sd255)
      return {1'b1, s, 8'hFF, 23'd0};
    else
      return {1'b0, s, e[7:0], frac};
  endfunction

  // Operand decode at acceptance: pick the larger magnitude as the base.
  logic [7:0]  ea, eb, diff;
  logic [26:0] ma, mb;
  logic [30:0] mag_a, mag_b;
  logic        a_ge, eop_in, sr_in;
  logic [4:0]  d_in;

  always_comb begin
    ea     = a[30:23];
    eb     = b[30:23];
    ma     = (ea == 8'd0) ? 27'd0 : {1'b1, a[22:0], 3'b000};
    mb     = (eb == 8'd0) ? 27'd0 : {1'b1, b[22:0], 3'b000};
    mag_a  = {ea, (ea == 8'd0) ? 23'd0 : a[22:0]};
    mag_b  = {eb, (eb == 8'd0) ? 23'd0 : b[22:0]};
    a_ge   = (mag_a >= mag_b);
    eop_in = a[31] ^ b[31] ^ op;
    sr_in  = eop_in ? (a_ge ? a[31] : (b[31] ^ op)) : a[31];
    diff   = a_ge ? (ea - eb) : (eb - ea);
    d_in   = (diff > 8'd27) ? 5'd27 : diff[4:0];
  end

  // Adder: base is never smaller than the aligned operand, so the difference is non-negative.
  logic [27:0] sum;
  always_comb begin
    if (eop)
      sum = {1'b0, mbig} - {1'b0, msml};
    else
      sum = {1'b0, mbig} + {1'b0, msml};
  end

  // Rounding and packing for the ROUND state.
  logic [24:0]       rm;
  logic signed [9:0] exp_rnd;
  logic [22:0]       frac_rnd;
  logic [32:0]       packed_v;
  always_comb begin
    rm       = round_rne(mbig);
    exp_rnd  = rm[24] ? (exp_r + 10'sd1) : exp_r;
    frac_rnd = rm[24] ? rm[23:1] : rm[22:0];
    packed_v = pack_sat(sr, exp_rnd, frac_rnd);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sr       <= 1'b0;
      eop      <= 1'b0;
      zero_r   <= 1'b0;
      exp_r    <= 10'sd0;
      mbig     <= 27'd0;
      msml     <= 27'd0;
      cnt      <= 5'd0;
      result_r <= 32'd0;
      ovf_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mbig   <= a_ge ? ma : mb;
            msml   <= a_ge ? mb : ma;
            exp_r  <= $signed({2'b00, (a_ge ? ea : eb)});
            cnt    <= d_in;
            sr     <= sr_in;
            eop    <= eop_in;
            zero_r <= 1'b0;
            state  <= ALIGN;
          end
        end
        ALIGN: begin
          if (cnt == 5'd0) begin
            state <= ADD;
          end else begin
            // Bits falling off the bottom accumulate into sticky.
            msml <= {1'b0, msml[26:2], msml[1] | msml[0]};
            cnt  <= cnt - 5'd1;
          end
        end
        ADD: begin
          if (sum == 28'd0) begin
            zero_r <= 1'b1;
            mbig   <= 27'd0;
            state  <= ROUND;
          end else if (sum[27]) begin
            mbig  <= {sum[27:2], sum[1] | sum[0]};
            exp_r <= exp_r + 10'sd1;
            state <= NORM;
          end else begin
            mbig  <= sum[26:0];
            state <= NORM;
          end
        end
        NORM: begin
          if (mbig[26]) begin
            state <= ROUND;
          end else if (exp_r > 10'sd1) begin
            mbig  <= {mbig[25:0], 1'b0};
            exp_r <= exp_r - 10'sd1;
          end else begin
            // Would go subnormal: flush.
            zero_r <= 1'b1;
            state  <= ROUND;
          end
        end
        ROUND: begin
          if (zero_r) begin
            result_r <= 32'd0;
            ovf_r    <= 1'b0;
          end else begin
            result_r <= packed_v[31:0];
            ovf_r    <= packed_v[32];
          end
          state <= DONE;
        end
        DONE: begin
          if (out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign result    = result_r;
  assign overflow  = ovf_r;

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Directed bench for fp_addsub_seq: table of operand pairs with hand-computed
// results and latencies, plus sequences for backpressure and mid-op reset.
module tb_fp_addsub_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        overflow;
  logic        busy;

  int n_cmp;
  int n_fail;

  fp_addsub_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] va;
    logic [31:0] vb;
    logic        vop;
    logic [31:0] exp_res;
    logic        exp_ovf;
    int          exp_lat;   // -1: latency not checked
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Issue one operation, wait for out_valid (bounded), take the result.
  task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input logic iop,
                        output logic [31:0] res, output logic ovf, output int lat);
    bit got;
    @(negedge clk);
    a = ia; b = ib; op = iop; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    got = 0;
    for (int c = 1; c <= 200; c++) begin
      lat = c;
      if (out_valid) begin
        got = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    // lat counts edges from acceptance; the first sample above is right after it.
    lat = lat - 1;
    if (!got) begin
      n_cmp++;
      n_fail++;
      $display("FAIL timeout: out_valid never rose, expected within 200 cycles");
      lat = -2;
    end
    res = result;
    ovf = overflow;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  vec_t        vecs[10];
  logic [31:0] res;
  logic        ovf;
  int          lat;

  initial begin
    n_cmp = 0; n_fail = 0;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = 1'b0; out_ready = 1'b0;

    vecs[0] = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 4};
    vecs[1] = '{32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 1'b0, 6};
    vecs[2] = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0, -1};
    vecs[3] = '{32'hBFC00000, 32'hC0200000, 1'b0, 32'hC0800000, 1'b0, 5};
    vecs[4] = '{32'h4B800000, 32'h3F800000, 1'b0, 32'h4B800000, 1'b0, 28};
    vecs[5] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 4};
    vecs[6] = '{32'h3F800001, 32'h3F800000, 1'b1, 32'h34000000, 1'b0, 27};
    vecs[7] = '{32'h40000000, 32'hBF800000, 1'b0, 32'h3F800000, 1'b0, 6};
    vecs[8] = '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 1'b0, 28};
    vecs[9] = '{32'h3F800000, 32'hBF800000, 1'b1, 32'h40000000, 1'b0, 4};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_result",    result,             32'd0);
    chk("reset_overflow",  {31'd0, overflow},  32'd0);
    chk("reset_busy",      {31'd0, busy},      32'd0);
    chk("reset_in_ready",  {31'd0, in_ready},  32'd1);

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].va, vecs[i].vb, vecs[i].vop, res, ovf, lat);
      chk($sformatf("vec%0d_result", i), res, vecs[i].exp_res);
      chk($sformatf("vec%0d_overflow", i), {31'd0, ovf}, {31'd0, vecs[i].exp_ovf});
      if (vecs[i].exp_lat >= 0)
        chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
    end

    // Backpressure: 2.0 + 2.0 held in DONE for 10 cycles with a stray in_valid pulse.
    @(negedge clk);
    a = 32'h40000000; b = 32'h40000000; op = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int c = 0; c < 200 && !out_valid; c++) begin
      @(posedge clk);
      #1;
    end
    chk("bp_out_valid_start", {31'd0, out_valid}, 32'd1);
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin
        a = 32'h7F7FFFFF; b = 32'h7F7FFFFF; op = 1'b0; in_valid = 1'b1;
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      chk($sformatf("bp_result_c%0d", c), result, 32'h40800000);
      chk($sformatf("bp_in_ready_c%0d", c), {31'd0, in_ready}, 32'd0);
      chk($sformatf("bp_out_valid_c%0d", c), {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("bp_release_in_ready",  {31'd0, in_ready},  32'd1);
    chk("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
    run_op(32'h3F800000, 32'h3F800000, 1'b0, res, ovf, lat);
    chk("bp_next_result",  res, 32'h40000000);
    chk("bp_next_latency", lat, 4);

    // Reset in ALIGN of a d=20 operation (2^20 + 1.0).
    @(negedge clk);
    a = 32'h49800000; b = 32'h3F800000; op = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy",      {31'd0, busy},      32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_result",    result,             32'd0);
    chk("rst_overflow",  {31'd0, overflow},  32'd0);
    run_op(32'h3F800000, 32'h3F800000, 1'b0, res, ovf, lat);
    chk("post_rst_result",  res, 32'h40000000);
    chk("post_rst_latency", lat, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_addsub_seq.md
# fp_addsub_seq

Multi-cycle sequencer for the single-precision floating-point add/subtract unit. It accepts two IEEE-754 operands and an add/subtract opcode over a valid/ready handshake. It derives the effective operation and result sign from the operand signs and the opcode, then steps the mantissa datapath through align, add, normalize and round before presenting the packed result. It sits between the FPU issue logic and the result writeback, and at most one operation is in flight.

## Interface
- No parameters; format fixed at binary32 (1/8/23).
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair presented
- in_ready  out  1  block idle, can accept; high iff state==IDLE
- a  in  32  operand A (Sa=a[31])
- b  in  32  operand B (Sb=b[31])
- op  in  1  0=A+B, 1=A−B
- out_valid  out  1  result valid, held until taken
- out_ready  in  1  consumer accepts result
- result  out  32  packed binary32 result
- overflow  out  1  result saturated to ±infinity; qualified by out_valid
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, ALIGN, ADD, NORM, ROUND, DONE.
- IDLE: on in_valid&&in_ready, the block registers the operands and enters ALIGN.
- Effective subtract: eop = Sa^Sb^op. Effective add (eop=0): Sr=Sa.
- Effective subtract: Sr=Sa if |A|≥|B|, else Sb^op. An exact zero difference gives +0.
- Inputs with exponent 0 are treated as ±0 (denormals flushed). Exponent 255 inputs are out of scope; behaviour is unspecified but must not hang the FSM.
- Mantissas are extended with the hidden bit and 3 extra LSBs (guard, round, sticky), giving 27 bits.
- ALIGN:
  - The larger-exponent operand is the base; the result exponent is initialised to its exponent.
  - The shift count is d=min(|ea−eb|,27).
  - One right shift of the smaller mantissa per cycle; shifted-out bits OR into sticky.
  - Exits to ADD when the remaining count is 0.
- ADD:
  - eop=0: sum, 28-bit.
  - eop=1: larger magnitude minus smaller.
  - On carry out, shift right 1 (sticky preserved) and increment the exponent.
  - A zero result goes straight to ROUND with result +0.
- NORM:
  - While bit 26 is clear and exponent >1: shift left 1 and decrement the exponent, one shift per cycle.
  - If bit 26 is still clear at exponent 1, flush to +0/Sr zero.
  - Exits when normalized.
- ROUND:
  - Round-to-nearest-even on guard/round/sticky.
  - A mantissa carry renormalizes and increments the exponent.
  - Exponent ≥255 produces result {Sr,8'hFF,23'h0} and overflow=1.
- DONE: out_valid=1 and result/overflow stable. On out_valid&&out_ready the block returns to IDLE.

## Timing
- Reset values: out_valid=0, result=0, overflow=0, busy=0, in_ready=1 (state IDLE). All internal registers clear.
- Latency from the acceptance edge to the first cycle of out_valid is 4+d+n cycles, where d is the align count and n is the number of NORM left shifts. The minimum is 4.
- ALIGN, ADD, NORM and ROUND each occupy at least 1 cycle.
- in_ready deasserts the cycle after acceptance. It reasserts the cycle after the out_valid&&out_ready edge, so back-to-back ops have one IDLE cycle between them.
- Backpressure: with out_ready low, DONE holds indefinitely with result unchanged.
- in_valid is ignored in every state except IDLE; operands are not re-sampled mid-operation.
- rst in any state forces all outputs to their reset values on the next edge and abandons the in-flight operation; rst has priority over the handshake.
- Exponent arithmetic is 10-bit signed internally to detect under/overflow. The packed exponent is the low 8 bits after the checks.

## Test plan
- 0x3F800000 + 0x3F800000, op=0 → result 0x40000000, overflow=0, out_valid exactly 4 cycles after accept.
- 0x3F800000 − 0x40000000 (op=1) → 0xBF800000. Separately, 0x3F800000 − 0x3F800000 → 0x00000000 (+0).
- 0xBFC00000 + 0xC0200000 (−1.5 + −2.5) → 0xC0800000. Then 0x4B800000 + 0x3F800000 → 0x4B800000 (tie to even) with latency 4+24.
- 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, overflow=1. 0x3F800001 − 0x3F800000 → 0x34000000 after 23 NORM shifts.
- Hold out_ready low 10 cycles in DONE → result stable, in_ready=0; pulse in_valid during this time → ignored. Release → IDLE, next op accepted one cycle later.
- Assert rst while in ALIGN of a d=20 op → next cycle out_valid=0, busy=0, in_ready=1, result=0. A following 1.0+1.0 completes correctly.
